alu_result_serializer: RTL and testbench



---
 rtl/alu_res_pkg.sv | 24 ++
 rtl/alu_res_bank.sv | 45 ++++
 rtl/alu_result_serializer.sv | 110 +++++++++++
 tb/tb_alu_result_serializer.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_res_pkg.sv
// Shared constants, word indices and FSM state type for the ALU result serializer.
package alu_res_pkg;

    localparam int WIDTH  = 32;
    localparam int NRES   = 9;
    localparam int NWORDS = 10;

    localparam logic [3:0] IDX_MUX1  = 4'd0;
    localparam logic [3:0] IDX_MUX2  = 4'd1;
    localparam logic [3:0] IDX_XOR   = 4'd2;
    localparam logic [3:0] IDX_AND   = 4'd3;
    localparam logic [3:0] IDX_OR    = 4'd4;
    localparam logic [3:0] IDX_ADD   = 4'd5;
    localparam logic [3:0] IDX_PERES = 4'd6;
    localparam logic [3:0] IDX_NAND  = 4'd7;
    localparam logic [3:0] IDX_NOR   = 4'd8;
    localparam logic [3:0] IDX_CSUM  = 4'd9;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage

// File: rtl/alu_res_bank.sv
// Nine-word snapshot register file with XOR checksum and index-addressed read mux.
module alu_res_bank #(
    parameter int WIDTH = 32,
    parameter int NRES  = 9
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cap_en,
    input  logic [NRES-1:0][WIDTH-1:0] words,
    input  logic [3:0]                 idx,
    output logic [WIDTH-1:0]           rd_data
);
    import alu_res_pkg::*;

    logic [NRES-1:0][WIDTH-1:0] bank;
    logic [WIDTH-1:0]           csum;
    logic [WIDTH-1:0]           csum_next;

    always_comb begin
        csum_next = '0;
        for (int i = 0; i < NRES; i++) begin
            csum_next = csum_next ^ words[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank <= '0;
            csum <= '0;
        end else if (cap_en) begin
            bank <= words;
            csum <= csum_next;
        end
    end

    always_comb begin
        rd_data = '0;
        if (idx == IDX_CSUM) begin
            rd_data = csum;
        end else if (int'(idx) < NRES) begin
            rd_data = bank[idx];
        end
    end

endmodule

// File: rtl/alu_result_serializer.sv
// Snapshots the nine ALU result buses on a capture strobe and streams them,
// followed by their XOR checksum, over a 32-bit valid/ready port.
module alu_result_serializer #(
    parameter int WIDTH = 32,
    parameter int NRES  = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cap_valid,
    output logic             cap_ready,
    input  logic [WIDTH-1:0] mux_result1,
    input  logic [WIDTH-1:0] mux_result2,
    input  logic [WIDTH-1:0] xor_result,
    input  logic [WIDTH-1:0] and_result,
    input  logic [WIDTH-1:0] or_result,
    input  logic [WIDTH-1:0] add_result,
    input  logic [WIDTH-1:0] mux_peres_result,
    input  logic [WIDTH-1:0] nand_result,
    input  logic [WIDTH-1:0] nor_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [3:0]       out_idx,
    output logic             out_last,
    output logic             overflow,
    input  logic             clr_ovf
);
    import alu_res_pkg::*;

    state_t                     state;
    state_t                     state_next;
    logic [3:0]                 idx;
    logic [3:0]                 idx_next;
    logic                       cap_fire;
    logic [WIDTH-1:0]           rd_data;
    logic [NRES-1:0][WIDTH-1:0] words;

    // Word 0 sits in the lowest slot so bank[idx] follows the output word order.
    assign words = {nor_result, nand_result, mux_peres_result, add_result,
                    or_result, and_result, xor_result, mux_result2, mux_result1};

    alu_res_bank #(
        .WIDTH (WIDTH),
        .NRES  (NRES)
    ) u_bank (
        .clk     (clk),
        .rst_n   (rst_n),
        .cap_en  (cap_fire),
        .words   (words),
        .idx     (idx),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
        end
    end

    always_comb begin
        state_next = state;
        idx_next   = idx;
        cap_ready  = 1'b0;
        out_valid  = 1'b0;
        cap_fire   = 1'b0;
        case (state)
            IDLE: begin
                cap_ready = 1'b1;
                if (cap_valid) begin
                    cap_fire   = 1'b1;
                    idx_next   = IDX_MUX1;
                    state_next = SEND;
                end
            end
            SEND: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (idx == IDX_CSUM) begin
                        idx_next   = '0;
                        state_next = IDLE;
                    end else begin
                        idx_next = idx + 4'd1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Data is forced to zero outside a frame so idle and reset look identical.
    assign out_data = out_valid ? rd_data : '0;
    assign out_idx  = idx;
    assign out_last = out_valid && (idx == IDX_CSUM);

    // A busy capture sets the flag; set beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (cap_valid && (state == SEND)) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_result_serializer.sv
// Scoreboard bench for alu_result_serializer: captures push ten expected beats, the consumer pops and compares.
module tb_alu_result_serializer;

    logic        clk;
    logic        rst_n;
    logic        cap_valid;
    logic        cap_ready;
    logic [31:0] mux_result1, mux_result2, xor_result, and_result, or_result;
    logic [31:0] add_result, mux_peres_result, nand_result, nor_result;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  out_idx;
    logic        out_last;
    logic        overflow;
    logic        clr_ovf;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    alu_result_serializer dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .cap_valid        (cap_valid),
        .cap_ready        (cap_ready),
        .mux_result1      (mux_result1),
        .mux_result2      (mux_result2),
        .xor_result       (xor_result),
        .and_result       (and_result),
        .or_result        (or_result),
        .add_result       (add_result),
        .mux_peres_result (mux_peres_result),
        .nand_result      (nand_result),
        .nor_result       (nor_result),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_data         (out_data),
        .out_idx          (out_idx),
        .out_last         (out_last),
        .overflow         (overflow),
        .clr_ovf          (clr_ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_words(input logic [8:0][31:0] w);
        mux_result1      = w[0];
        mux_result2      = w[1];
        xor_result       = w[2];
        and_result       = w[3];
        or_result        = w[4];
        add_result       = w[5];
        mux_peres_result = w[6];
        nand_result      = w[7];
        nor_result       = w[8];
    endtask

    // Called at a falling edge while idle; returns at the falling edge showing beat 0.
    task automatic capture(input logic [8:0][31:0] w);
        logic [31:0] cs;
        cs = '0;
        set_words(w);
        cap_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            exp_q.push_back(w[i]);
            cs = cs ^ w[i];
        end
        exp_q.push_back(cs);
        @(negedge clk);
        cap_valid = 1'b0;
    endtask

    function automatic logic [31:0] pop_exp();
        if (exp_q.size() == 0) return 'x;
        return exp_q.pop_front();
    endfunction

    task automatic test_reset();
        #3;
        checks++;
        if (cap_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 32'h0 ||
            out_idx !== 4'd0 || out_last !== 1'b0 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: got cap_ready=%b out_valid=%b data=%h idx=%0d last=%b ovf=%b, want 1 0 0 0 0 0",
                     cap_ready, out_valid, out_data, out_idx, out_last, overflow);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic_frame();
        logic [8:0][31:0] w;
        logic [31:0] e;
        for (int i = 0; i < 9; i++) w[i] = 32'(i + 1);
        out_ready = 1'b1;
        capture(w);
        for (int b = 0; b < 10; b++) begin
            e = pop_exp();
            checks++;
            if (out_valid !== 1'b1 || out_data !== e || out_idx !== b[3:0] || out_last !== (b == 9)) begin
                failures++;
                $display("FAIL basic_beat%0d: got valid=%b data=%h idx=%0d last=%b, want 1 %h %0d %b",
                         b, out_valid, out_data, out_idx, out_last, e, b, (b == 9));
            end
            if (b == 9) begin
                checks++;
                if (out_data !== 32'h0000_0001) begin
                    failures++;
                    $display("FAIL basic_csum: got %h want 00000001", out_data);
                end
            end
            @(negedge clk);
        end
        checks++;
        if (cap_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_idle_after: got cap_ready=%b out_valid=%b want 1 0", cap_ready, out_valid);
        end
    endtask

    task automatic test_backpressure();
        logic [8:0][31:0] w;
        logic [31:0] e;
        // A=AAAAAAAA, B=55555555: add, xor, or, nand all-ones; four of them cancel in the checksum.
        w = '0;
        w[2] = 32'hFFFF_FFFF;
        w[4] = 32'hFFFF_FFFF;
        w[5] = 32'hFFFF_FFFF;
        w[7] = 32'hFFFF_FFFF;
        out_ready = 1'b1;
        capture(w);
        for (int b = 0; b < 10; b++) begin
            if (b == 2) begin
                out_ready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    checks++;
                    if (out_valid !== 1'b1 || out_data !== 32'hFFFF_FFFF || out_idx !== 4'd2 || out_last !== 1'b0) begin
                        failures++;
                        $display("FAIL bp_stall%0d: got valid=%b data=%h idx=%0d last=%b, want 1 ffffffff 2 0",
                                 s, out_valid, out_data, out_idx, out_last);
                    end
                    @(negedge clk);
                end
                out_ready = 1'b1;
            end
            e = pop_exp();
            checks++;
            if (out_valid !== 1'b1 || out_data !== e || out_idx !== b[3:0] || out_last !== (b == 9)) begin
                failures++;
                $display("FAIL bp_beat%0d: got valid=%b data=%h idx=%0d last=%b, want 1 %h %0d %b",
                         b, out_valid, out_data, out_idx, out_last, e, b, (b == 9));
            end
            if (b == 9) begin
                checks++;
                if (out_data !== 32'h0) begin
                    failures++;
                    $display("FAIL bp_csum: got %h want 00000000", out_data);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_busy_capture();
        logic [8:0][31:0] w;
        logic [8:0][31:0] w2;
        logic [31:0] e;
        for (int i = 0; i < 9; i++) begin
            w[i]  = $urandom;
            w2[i] = ~w[i];
        end
        out_ready = 1'b1;
        capture(w);
        for (int b = 0; b < 10; b++) begin
            e = pop_exp();
            checks++;
            if (out_valid !== 1'b1 || out_data !== e || out_idx !== b[3:0]) begin
                failures++;
                $display("FAIL busy_beat%0d: got valid=%b data=%h idx=%0d, want 1 %h %0d",
                         b, out_valid, out_data, out_idx, e, b);
            end
            if (b > 4) begin
                checks++;
                if (overflow !== 1'b1) begin
                    failures++;
                    $display("FAIL busy_ovf_beat%0d: got %b want 1", b, overflow);
                end
            end
            if (b == 4) begin
                set_words(w2);
                cap_valid = 1'b1;
            end
            @(negedge clk);
            cap_valid = 1'b0;
        end
        checks++;
        if (overflow !== 1'b1 || cap_ready !== 1'b1) begin
            failures++;
            $display("FAIL busy_ovf_sticky: got ovf=%b cap_ready=%b want 1 1", overflow, cap_ready);
        end
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            failures++;
            $display("FAIL busy_ovf_clear: got %b want 0", overflow);
        end
    endtask

    task automatic test_set_clear_collision();
        logic [8:0][31:0] w;
        logic [31:0] e;
        for (int i = 0; i < 9; i++) w[i] = $urandom;
        out_ready = 1'b1;
        capture(w);
        for (int b = 0; b < 10; b++) begin
            e = pop_exp();
            checks++;
            if (out_valid !== 1'b1 || out_data !== e || out_idx !== b[3:0]) begin
                failures++;
                $display("FAIL coll_beat%0d: got valid=%b data=%h idx=%0d, want 1 %h %0d",
                         b, out_valid, out_data, out_idx, e, b);
            end
            if (b == 4) begin
                checks++;
                if (overflow !== 1'b1) begin
                    failures++;
                    $display("FAIL coll_set_wins: got %b want 1", overflow);
                end
            end
            if (b == 3) begin
                cap_valid = 1'b1;
                clr_ovf   = 1'b1;
            end
            @(negedge clk);
            cap_valid = 1'b0;
            clr_ovf   = 1'b0;
        end
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        logic [8:0][31:0] w;
        logic [31:0] e;
        for (int i = 0; i < 9; i++) w[i] = $urandom;
        out_ready = 1'b1;
        capture(w);
        for (int b = 0; b < 10; b++) begin
            if (b == 6) begin
                rst_n = 1'b0;
                #1;
                checks++;
                if (cap_ready !== 1'b1 || out_valid !== 1'b0 || out_idx !== 4'd0 ||
                    overflow !== 1'b0 || out_data !== 32'h0 || out_last !== 1'b0) begin
                    failures++;
                    $display("FAIL midreset_state: got cap_ready=%b valid=%b idx=%0d ovf=%b data=%h last=%b, want 1 0 0 0 0 0",
                             cap_ready, out_valid, out_idx, overflow, out_data, out_last);
                end
                break;
            end
            e = pop_exp();
            checks++;
            if (out_valid !== 1'b1 || out_data !== e || out_idx !== b[3:0]) begin
                failures++;
                $display("FAIL midreset_pre_beat%0d: got valid=%b data=%h idx=%0d, want 1 %h %0d",
                         b, out_valid, out_data, out_idx, e, b);
            end
            if (b == 5) cap_valid = 1'b1;
            @(negedge clk);
            cap_valid = 1'b0;
        end
        exp_q.delete();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || cap_ready !== 1'b1) begin
            failures++;
            $display("FAIL midreset_no_resume: got valid=%b cap_ready=%b want 0 1", out_valid, cap_ready);
        end
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 9; i++) w[i] = 32'h1234_5678;
        capture(w);
        for (int b = 0; b < 10; b++) begin
            e = pop_exp();
            checks++;
            if (out_valid !== 1'b1 || out_data !== e || out_idx !== b[3:0] || out_last !== (b == 9)) begin
                failures++;
                $display("FAIL midreset_beat%0d: got valid=%b data=%h idx=%0d last=%b, want 1 %h %0d %b",
                         b, out_valid, out_data, out_idx, out_last, e, b, (b == 9));
            end
            if (b == 9) begin
                checks++;
                if (out_data !== 32'h1234_5678) begin
                    failures++;
                    $display("FAIL midreset_csum: got %h want 12345678", out_data);
                end
            end
            @(negedge clk);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        cap_valid = 1'b0;
        out_ready = 1'b0;
        clr_ovf   = 1'b0;
        set_words('0);

        test_reset();
        test_basic_frame();
        test_backpressure();
        test_busy_capture();
        test_set_clear_collision();
        test_reset_mid_frame();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
